// File: rtl/bram_arb2_ctrl.sv
// bram_arb2_ctrl: round-robin two-port sequencer for one single-port BRAM; read data returns RD_LAT cycles after accept (RD_LAT+1 with BRAM_ARB_OUTREG_EN).
// Backpressure: one command accepted per cycle through reqN_ready; responses are never stalled.
module bram_arb2_ctrl #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_wen,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_wen,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wen,
    input  logic [DW-1:0] ram_rdata
);

    logic              r_last_grant;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_id;

    logic w_gnt0;
    logic w_gnt1;
    logic w_acc0;
    logic w_acc1;
    logic w_rd_acc;
    logic w_tail_vld;
    logic w_rsp0_vld;
    logic w_rsp1_vld;

    // A lone requester always wins; on a tie the port not granted last wins.
    assign w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);

    assign req0_ready = ~reset & w_gnt0;
    assign req1_ready = ~reset & w_gnt1;
    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1     = req1_valid & req1_ready;
    assign w_rd_acc   = (w_acc0 & ~req0_wen) | (w_acc1 & ~req1_wen);

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wen   = 1'b0;
        if (w_acc0) begin
            ram_addr  = req0_addr;
            ram_wdata = req0_wdata;
            ram_wen   = req0_wen;
        end else if (w_acc1) begin
            ram_addr  = req1_addr;
            ram_wdata = req1_wdata;
            ram_wen   = req1_wen;
        end
    end

    // Tag pipeline mirrors the BRAM read latency so the tail lines up with ram_rdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_tag_vld    <= '0;
            r_tag_id     <= '0;
        end else begin
            if (w_acc0) begin
                r_last_grant <= 1'b0;
            end else if (w_acc1) begin
                r_last_grant <= 1'b1;
            end
            r_tag_vld[0] <= w_rd_acc;
            r_tag_id[0]  <= w_acc1;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    assign w_tail_vld = r_tag_vld[RD_LAT-1] & ~reset;
    assign w_rsp0_vld = w_tail_vld & ~r_tag_id[RD_LAT-1];
    assign w_rsp1_vld = w_tail_vld &  r_tag_id[RD_LAT-1];

`ifdef BRAM_ARB_OUTREG_EN
    logic          r_rsp0_vld;
    logic          r_rsp1_vld;
    logic [DW-1:0] r_rsp0_rdata;
    logic [DW-1:0] r_rsp1_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp0_vld   <= 1'b0;
            r_rsp1_vld   <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_vld   <= w_rsp0_vld;
            r_rsp1_vld   <= w_rsp1_vld;
            r_rsp0_rdata <= w_rsp0_vld ? ram_rdata : '0;
            r_rsp1_rdata <= w_rsp1_vld ? ram_rdata : '0;
        end
    end

    assign rsp0_valid = r_rsp0_vld & ~reset;
    assign rsp1_valid = r_rsp1_vld & ~reset;
    assign rsp0_rdata = rsp0_valid ? r_rsp0_rdata : '0;
    assign rsp1_rdata = rsp1_valid ? r_rsp1_rdata : '0;
`else
    assign rsp0_valid = w_rsp0_vld;
    assign rsp1_valid = w_rsp1_vld;
    assign rsp0_rdata = w_rsp0_vld ? ram_rdata : '0;
    assign rsp1_rdata = w_rsp1_vld ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_bram_arb2_ctrl.sv
// Bench for bram_arb2_ctrl: behavioural 256x8 BRAM plus a queue-based reference of arbitration and read returns.
module tb_bram_arb2_ctrl;

`ifdef BRAM_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock;
    logic       reset;
    logic       req0_valid, req0_ready, req0_wen, rsp0_valid;
    logic [7:0] req0_addr, req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_ready, req1_wen, rsp1_valid;
    logic [7:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_wen;

    bram_arb2_ctrl #(.AW(8), .DW(8), .RD_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ram_rdata(ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a * 8'd37 + 8'd11;
    endfunction

    // Behavioural single-port BRAM, read-before-write, one cycle read latency.
    logic [7:0] bram [256];
    bit         bram_wr [256];
    always @(posedge clock) begin
        if (ram_wen) begin
            bram[ram_addr]    <= ram_wdata;
            bram_wr[ram_addr] <= 1'b1;
        end
        ram_rdata <= bram_wr[ram_addr] ? bram[ram_addr] : init_val(ram_addr);
    end

    typedef struct {
        int         due;
        bit         port;
        logic [7:0] data;
    } rsp_t;

    rsp_t        pq[$];
    logic [7:0]  m_mem [256];
    bit          m_lg;
    int          cyc;
    int          vectors;
    int          miscompares;

    logic [36:0] obs, exp_v;
    logic        o_rdy0, o_rdy1, o_rv0, o_rv1;
    logic [7:0]  o_rd0, o_rd1;

    task automatic drive0(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        req0_valid = v; req0_wen = w; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        req1_valid = v; req1_wen = w; req1_addr = a; req1_wdata = d;
    endtask

    // Samples the DUT, advances the reference by one cycle, then steps to the next falling edge.
    task automatic tick();
        logic       e_rdy0, e_rdy1, e_wen, e_rv0, e_rv1;
        logic [7:0] e_addr, e_wdata, e_rd0, e_rd1;
        int         win;
        rsp_t       r;
        #1;
        obs = {req0_ready, req1_ready, ram_wen, ram_addr, ram_wdata,
               rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata};
        o_rdy0 = req0_ready; o_rdy1 = req1_ready;
        o_rv0 = rsp0_valid; o_rd0 = rsp0_rdata;
        o_rv1 = rsp1_valid; o_rd1 = rsp1_rdata;
        {e_rdy0, e_rdy1, e_wen, e_rv0, e_rv1} = '0;
        {e_addr, e_wdata, e_rd0, e_rd1} = '0;
        if (reset) begin
            pq.delete();
            m_lg = 1'b1;
        end else begin
            if (pq.size() > 0 && pq[0].due == cyc) begin
                r = pq.pop_front();
                if (r.port) begin e_rv1 = 1'b1; e_rd1 = r.data; end
                else        begin e_rv0 = 1'b1; e_rd0 = r.data; end
            end
            win = -1;
            if (req0_valid && req1_valid) win = m_lg ? 0 : 1;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
            if (win >= 0) begin
                e_rdy0  = (win == 0);
                e_rdy1  = (win == 1);
                e_wen   = (win == 0) ? req0_wen   : req1_wen;
                e_addr  = (win == 0) ? req0_addr  : req1_addr;
                e_wdata = (win == 0) ? req0_wdata : req1_wdata;
                m_lg    = (win == 1);
                if (e_wen) begin
                    m_mem[e_addr] = e_wdata;
                end else begin
                    r.due = cyc + LAT; r.port = (win == 1); r.data = m_mem[e_addr];
                    pq.push_back(r);
                end
            end
        end
        exp_v = {e_rdy0, e_rdy1, e_wen, e_addr, e_wdata, e_rv0, e_rd0, e_rv1, e_rd1};
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive0(1'b1, 1'b1, 8'h12, 8'h34);
        drive1(1'b1, 1'b0, 8'h56, 8'h78);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== 37'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc, obs);
            end
        end
        drive0(1'b0, 1'b0, 8'h0, 8'h0);
        drive1(1'b0, 1'b0, 8'h0, 8'h0);
        reset = 1'b0;
    endtask

    task automatic test_single_port();
        drive0(1'b1, 1'b1, 8'h05, 8'h15);
        tick();
        vectors++;
        if (obs !== exp_v || o_rdy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_write cyc=%0d got=%h want=%h", cyc, obs, exp_v);
        end
        drive0(1'b1, 1'b0, 8'h05, 8'h00);
        tick();
        vectors++;
        if (obs !== exp_v || o_rdy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_read_accept cyc=%0d got=%h want=%h", cyc, obs, exp_v);
        end
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v || {o_rv0, o_rd0, o_rv1} !== ((k == LAT) ? {1'b1, 8'h15, 1'b0} : 10'd0)) begin
                miscompares++;
                $display("FAIL single_read_rsp k=%0d got v0=%b d0=%h v1=%b want v0=%b d0=15", k, o_rv0, o_rd0, o_rv1, k == LAT);
            end
        end
    endtask

    task automatic test_saturation();
        int c0, c1;
        c0 = 0; c1 = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive0(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        drive1(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (obs !== exp_v || {o_rdy0, o_rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL saturation_grant i=%0d got rdy=%b%b obs=%h want=%h", i, o_rdy0, o_rdy1, obs, exp_v);
            end
            if (o_rdy0) begin c0++; drive0(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom)); end
            if (o_rdy1) begin c1++; drive1(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom)); end
        end
        drive0(1'b0, 1'b0, 8'h0, 8'h0);
        drive1(1'b0, 1'b0, 8'h0, 8'h0);
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL saturation_drain cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
        end
        vectors++;
        if (c0 != 4 || c1 != 4) begin
            miscompares++;
            $display("FAIL saturation_counts got %0d/%0d want 4/4", c0, c1);
        end
    endtask

    // Both ports issue one command each in the same cycle; records when and what each port gets back.
    task automatic run_pair(input string name, output int t0, output logic [7:0] d0,
                            output int t1, output logic [7:0] d1);
        t0 = -1; t1 = -1; d0 = 8'h0; d1 = 8'h0;
        for (int k = 0; k < LAT + 3; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL %s k=%0d got=%h want=%h", name, k, obs, exp_v);
            end
            if (o_rdy0) req0_valid = 1'b0;
            if (o_rdy1) req1_valid = 1'b0;
            if (o_rv0) begin t0 = k; d0 = o_rd0; end
            if (o_rv1) begin t1 = k; d1 = o_rd1; end
        end
    endtask

    task automatic test_tie_same_addr();
        int t0, t1;
        logic [7:0] d0, d1;
        drive1(1'b1, 1'b1, 8'h07, 8'h17);
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        run_pair("tie_write", t0, d0, t1, d1);
        drive0(1'b1, 1'b0, 8'h07, 8'h00);
        drive1(1'b1, 1'b0, 8'h07, 8'h00);
        run_pair("tie_read", t0, d0, t1, d1);
        vectors++;
        if (t0 != LAT || d0 !== 8'h17 || t1 != LAT + 1 || d1 !== 8'h17) begin
            miscompares++;
            $display("FAIL tie_rsp got t0=%0d d0=%h t1=%0d d1=%h want t0=%0d t1=%0d data 17", t0, d0, t1, d1, LAT, LAT + 1);
        end
    endtask

    task automatic test_wrap();
        int t0, t1;
        logic [7:0] d0, d1;
        drive0(1'b1, 1'b1, 8'hFF, 8'hAA);
        drive1(1'b1, 1'b1, 8'h00, 8'h55);
        run_pair("wrap_write", t0, d0, t1, d1);
        drive0(1'b1, 1'b0, 8'h00, 8'h00);
        drive1(1'b1, 1'b0, 8'hFF, 8'h00);
        run_pair("wrap_read", t0, d0, t1, d1);
        vectors++;
        if (d0 !== 8'h55 || d1 !== 8'hAA || t0 < 0 || t1 < 0) begin
            miscompares++;
            $display("FAIL wrap_rsp got d0=%h d1=%h t0=%0d t1=%0d want d0=55 d1=AA", d0, d1, t0, t1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        drive1(1'b0, 1'b0, 8'h0, 8'h0);
        for (int k = 0; k < 4 + LAT + 1; k++) begin
            case (k)
                0: drive0(1'b1, 1'b1, 8'h30, 8'h11);
                1: drive0(1'b1, 1'b0, 8'h30, 8'h00);
                2: drive0(1'b1, 1'b1, 8'h30, 8'hC3);
                3: drive0(1'b1, 1'b0, 8'h30, 8'h00);
                default: drive0(1'b0, 1'b0, 8'h00, 8'h00);
            endcase
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL b2b k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (o_rv0) got.push_back(o_rd0);
        end
        vectors++;
        if (got.size() != 2 || got[0] !== 8'h11 || got[1] !== 8'hC3) begin
            miscompares++;
            $display("FAIL b2b_order got n=%0d first=%h want 2 rsps 11,C3", got.size(), (got.size() > 0) ? got[0] : 8'h0);
        end
    endtask

    task automatic test_reset_mid_read();
        drive0(1'b1, 1'b0, 8'h07, 8'h00);
        drive1(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        vectors++;
        if (obs !== exp_v || o_rdy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_accept got=%h want=%h", obs, exp_v);
        end
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < LAT + 1; k++) begin
            if (k > 0) tick();
            vectors++;
            if (o_rv0 !== 1'b0 || o_rv1 !== 1'b0 || obs !== exp_v) begin
                miscompares++;
                $display("FAIL rst_mid_no_rsp k=%0d got v0=%b v1=%b want 0 0", k, o_rv0, o_rv1);
            end
        end
        drive0(1'b1, 1'b0, 8'h07, 8'h00);
        drive1(1'b1, 1'b0, 8'h05, 8'h00);
        tick();
        vectors++;
        if ({o_rdy0, o_rdy1} !== 2'b10 || obs !== exp_v) begin
            miscompares++;
            $display("FAIL rst_mid_first_tie got rdy=%b%b want 10", o_rdy0, o_rdy1);
        end
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL rst_mid_drain k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (o_rdy1) req1_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            if (!req0_valid && $urandom_range(0, 2) != 0)
                drive0(1'b1, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)), 8'($urandom));
            if (!req1_valid && $urandom_range(0, 2) != 0)
                drive1(1'b1, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 15)), 8'($urandom));
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            if (o_rdy0) req0_valid = 1'b0;
            if (o_rdy1) req1_valid = 1'b0;
        end
        reset = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        m_lg = 1'b1;
        for (int a = 0; a < 256; a++) m_mem[a] = init_val(8'(a));
        test_reset();
        test_single_port();
        test_saturation();
        test_tie_same_addr();
        test_wrap();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
